// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder.
// Ports (signals): in_valid/in_ready/a/b/sub upstream, out_valid/out_ready/sum/cout/ovf downstream.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep sliced add/subtract with registered inter-slice carry.
// Ports: clk, rst (sync, active-high), bus (pipelined_adder_if.slave: operands in, sum/cout/ovf out).
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);
    localparam int W = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: invalid WIDTH/STAGES combination");
    end

    // Per-stage registers: skewed operands, de-skewed partial sum, carry, valid.
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    logic [WIDTH-1:0] w_a  [STAGES];
    logic [WIDTH-1:0] w_b  [STAGES];
    logic [WIDTH-1:0] w_s  [STAGES];
    logic             w_ci [STAGES];
    logic             w_v  [STAGES];
    logic [W:0]       w_sl [STAGES];
    logic             w_ovf;
    logic             w_stall;

    assign w_stall       = r_v[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.sum       = r_s[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
    assign bus.ovf       = r_ovf;

    always_comb begin
        w_a  = '{default: '0};
        w_b  = '{default: '0};
        w_s  = '{default: '0};
        w_ci = '{default: 1'b0};
        w_v  = '{default: 1'b0};
        w_sl = '{default: '0};

        // Stage 0 takes operands straight from the bus; B is inverted
        // and sub is the carry-in, giving A + ~B + 1 for subtract.
        w_a[0]  = bus.a;
        w_b[0]  = bus.b ^ {WIDTH{bus.sub}};
        w_ci[0] = bus.sub;
        w_v[0]  = bus.in_valid;
        w_s[0]  = '0;

        for (int k = 1; k < STAGES; k++) begin
            w_a[k]  = r_a[k-1];
            w_b[k]  = r_b[k-1];
            w_ci[k] = r_c[k-1];
            w_v[k]  = r_v[k-1];
            w_s[k]  = r_s[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            w_sl[k] = {1'b0, w_a[k][k*W +: W]}
                    + {1'b0, w_b[k][k*W +: W]}
                    + {{W{1'b0}}, w_ci[k]};
            w_s[k][k*W +: W] = w_sl[k][W-1:0];
        end

        // Carry into the MSB is recovered as a^b^s at that bit.
        w_ovf = w_a[STAGES-1][WIDTH-1] ^ w_b[STAGES-1][WIDTH-1]
              ^ w_s[STAGES-1][WIDTH-1] ^ w_sl[STAGES-1][W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '{default: '0};
            r_b   <= '{default: '0};
            r_s   <= '{default: '0};
            r_c   <= '{default: 1'b0};
            r_v   <= '{default: 1'b0};
            r_ovf <= 1'b0;
        end else if (!w_stall) begin
            r_a   <= w_a;
            r_b   <= w_b;
            r_s   <= w_s;
            r_v   <= w_v;
            r_ovf <= w_ovf;
            for (int k = 0; k < STAGES; k++) begin
                r_c[k] <= w_sl[k][W];
            end
        end
    end
endmodule
